// File: rtl/neuron_mac.sv
// Neuron pre-activation MAC: z = sat32(bias + sum(x_i * w_i)) in Q15.16.
// Beats arrive on a valid/ready stream; the result is held on a valid/ready
// output until the downstream sigmoid stage consumes it.
module neuron_mac #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned BITS     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] bias,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] x_in,
  input  logic [BITS-1:0] w_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] z_out,
  output logic            sat,
  output logic            busy
);

  // Headroom of clog2(N_INPUTS+1) bits above the 48-bit shifted product means
  // the running sum can never wrap, so saturation is decided once at the end.
  localparam int unsigned ProdW = 2 * BITS;
  localparam int unsigned AccW  = ProdW - 16 + $clog2(N_INPUTS + 1);
  localparam int unsigned CntW  = $clog2(N_INPUTS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

  state_e state_q, state_d;

  logic signed [AccW-1:0]  acc_q, acc_d;
  logic        [CntW-1:0]  cnt_q, cnt_d;
  logic        [BITS-1:0]  z_q, z_d;
  logic                    sat_q, sat_d;

  logic                    xfer;
  logic signed [ProdW-1:0] x_ext;
  logic signed [ProdW-1:0] w_ext;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  bias_ext;
  logic signed [AccW-1:0]  acc_sum;
  logic [AccW-BITS:0]      sum_top;
  logic                    sum_fits;
  logic [BITS-1:0]         sum_clip;

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign z_out     = z_q;
  assign sat       = sat_q;

  assign xfer = in_valid & in_ready;

  // Full-width signed product, then arithmetic shift by 16 (floor rounding)
  // truncated into the accumulator width; dropped top bits are pure sign.
  always_comb begin
    x_ext    = {{BITS{x_in[BITS-1]}}, x_in};
    w_ext    = {{BITS{w_in[BITS-1]}}, w_in};
    prod     = x_ext * w_ext;
    bias_ext = {{(AccW - BITS){bias[BITS-1]}}, bias};
    acc_sum  = acc_q + AccW'(prod >>> 16);
  end

  // Saturate the post-beat sum: it fits iff every bit from BITS-1 up is a sign copy.
  always_comb begin
    sum_top  = acc_sum[AccW-1:BITS-1];
    sum_fits = (&sum_top) | ~(|sum_top);
    if (sum_fits) begin
      sum_clip = acc_sum[BITS-1:0];
    end else if (acc_sum[AccW-1]) begin
      sum_clip = {1'b1, {(BITS - 1){1'b0}}};
    end else begin
      sum_clip = {1'b0, {(BITS - 1){1'b1}}};
    end
  end

  // Next-state and datapath update for the IDLE/ACC/OUT controller.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (xfer) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Capture the result from the final sum so out_valid rises next cycle.
            z_d     = sum_clip;
            sat_d   = ~sum_fits;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, beat counter and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      z_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      z_q   <= z_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: one 4-input and one 1-input instance.
module tb_neuron_mac;

  logic clk;
  logic rst;

  logic        start4, in_valid4, out_ready4;
  logic [31:0] bias4, x4, w4;
  logic        in_ready4, out_valid4, sat4, busy4;
  logic [31:0] z4;

  logic        start1, in_valid1, out_ready1;
  logic [31:0] bias1, x1, w1;
  logic        in_ready1, out_valid1, sat1, busy1;
  logic [31:0] z1;

  int total;
  int bad;

  neuron_mac #(
    .N_INPUTS(4),
    .BITS    (32)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
    .bias     (bias4),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .x_in     (x4),
    .w_in     (w4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .z_out    (z4),
    .sat      (sat4),
    .busy     (busy4)
  );

  neuron_mac #(
    .N_INPUTS(1),
    .BITS    (32)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .bias     (bias1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .x_in     (x1),
    .w_in     (w1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .z_out    (z1),
    .sat      (sat1),
    .busy     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One evaluation on the 4-input instance. gaps>0 inserts idle beats with
  // start pulses; hold cycles keep out_ready low with start pulses.
  task automatic eval4(input string tag, input logic [31:0] b, input logic [31:0] x,
                       input logic [31:0] w, input int gaps, input int hold,
                       input logic [31:0] exp_z, input logic exp_sat);
    @(negedge clk);
    start4 = 1'b1;
    bias4  = b;
    @(negedge clk);
    start4 = 1'b0;
    bias4  = 32'hDEAD_BEEF;
    check({tag, ".busy_acc"}, busy4, 1);
    check({tag, ".rdy_acc"}, in_ready4, 1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps * (i % 3); g++) begin
        in_valid4 = 1'b0;
        start4    = 1'b1;
        bias4     = 32'h1234_5678;
        @(negedge clk);
        start4    = 1'b0;
      end
      in_valid4 = 1'b1;
      x4        = x;
      w4        = w;
      @(negedge clk);
      in_valid4 = 1'b0;
      if (i < 3) begin
        check({tag, ".ov_early"}, out_valid4, 0);
      end
    end
    check({tag, ".ov"}, out_valid4, 1);
    check({tag, ".z"}, z4, exp_z);
    check({tag, ".sat"}, sat4, exp_sat);
    for (int h = 0; h < hold; h++) begin
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      check({tag, ".ov_hold"}, out_valid4, 1);
      check({tag, ".z_hold"}, z4, exp_z);
      check({tag, ".sat_hold"}, sat4, exp_sat);
    end
    out_ready4 = 1'b1;
    start4     = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    start4     = 1'b0;
    check({tag, ".ov_done"}, out_valid4, 0);
    check({tag, ".busy_done"}, busy4, 0);
  endtask

  // One evaluation on the 1-input instance.
  task automatic eval1(input string tag, input logic [31:0] b, input logic [31:0] x,
                       input logic [31:0] w, input logic [31:0] exp_z, input logic exp_sat);
    @(negedge clk);
    start1 = 1'b1;
    bias1  = b;
    @(negedge clk);
    start1    = 1'b0;
    in_valid1 = 1'b1;
    x1        = x;
    w1        = w;
    check({tag, ".rdy"}, in_ready1, 1);
    @(negedge clk);
    in_valid1 = 1'b0;
    check({tag, ".ov"}, out_valid1, 1);
    check({tag, ".z"}, z1, exp_z);
    check({tag, ".sat"}, sat1, exp_sat);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check({tag, ".ov_done"}, out_valid1, 0);
    check({tag, ".busy_done"}, busy1, 0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    start4     = 1'b0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    bias4      = '0;
    x4         = '0;
    w4         = '0;
    start1     = 1'b0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    bias1      = '0;
    x1         = '0;
    w1         = '0;

    #1;
    check("rst.z", z4, 0);
    check("rst.ov", out_valid4, 0);
    check("rst.rdy", in_ready4, 0);
    check("rst.busy", busy4, 0);
    check("rst.sat", sat4, 0);
    check("rst1.busy", busy1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 4 x (1.0 * 0.5) = 2.0
    eval4("half", 32'h0, 32'h0001_0000, 32'h0000_8000, 0, 0, 32'h0002_0000, 1'b0);
    // 4 x (-1.0 * 0.25) + 0.25 = -0.75
    eval4("neg", 32'h0000_4000, 32'hFFFF_0000, 32'h0000_4000, 0, 0, 32'hFFFF_4000, 1'b0);
    // Exact extremes via bias only must not be flagged as clipped.
    eval4("maxb", 32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 0, 0, 32'h7FFF_FFFF, 1'b0);
    eval4("minb", 32'h8000_0000, 32'h0, 32'h0001_0000, 0, 0, 32'h8000_0000, 1'b0);
    // Backpressure and ignored start pulses.
    eval4("bp", 32'h0, 32'h0001_0000, 32'h0000_8000, 2, 3, 32'h0002_0000, 1'b0);
    eval4("satp", 32'h0, 32'h7FFF_0000, 32'h0002_0000, 0, 0, 32'h7FFF_FFFF, 1'b1);
    eval4("satn", 32'h0, 32'h7FFF_0000, 32'hFFFE_0000, 0, 0, 32'h8000_0000, 1'b1);

    // Floor rounding of the shifted product.
    eval1("trp", 32'h0, 32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b0);
    eval1("trn", 32'h0, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0);
    // 2.0 * 3.0 + 1.0 = 7.0
    eval1("one", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0007_0000, 1'b0);

    // Reset in the middle of an accumulation (z_out still holds 0x8000_0000).
    @(negedge clk);
    start4 = 1'b1;
    bias4  = 32'h0;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid4 = 1'b1;
      x4        = 32'h0001_0000;
      w4        = 32'h0000_8000;
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mrst.z", z4, 0);
    check("mrst.sat", sat4, 0);
    check("mrst.ov", out_valid4, 0);
    check("mrst.rdy", in_ready4, 0);
    check("mrst.busy", busy4, 0);
    @(negedge clk);
    rst = 1'b0;
    eval4("post", 32'h0, 32'h0001_0000, 32'h0000_8000, 0, 0, 32'h0002_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
